// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and tick arithmetic for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    function automatic int ms_cnt_max(input int sys_cycle, input int ms_wait_time);
        return ms_wait_time / sys_cycle - 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - lock/request inputs and staged reset outputs of the sequencer
interface reset_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic              lock_i;
    logic              soft_rst_req;
    logic [NUM_CH-1:0] rst_o;
    logic [NUM_CH-1:0] rst_n_o;
    logic              done_o;
    logic [1:0]        state_o;

    modport master (
        input  lock_i, soft_rst_req,
        output rst_o, rst_n_o, done_o, state_o
    );

    modport slave (
        output lock_i, soft_rst_req,
        input  rst_o, rst_n_o, done_o, state_o
    );
endinterface

// File: rtl/reset_sequencer_ms_tick_gen.sv
// rtl/reset_sequencer_ms_tick_gen.sv - gated millisecond tick counter, held at zero while disabled
module ms_tick_gen
    import reset_seq_pkg::*;
#(
    parameter int SYS_CYCLE    = 20,
    parameter int MS_WAIT_TIME = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CNT_MAX = ms_cnt_max(SYS_CYCLE, MS_WAIT_TIME);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

    logic [CW-1:0] ms_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_cnt <= '0;
        end else if (!en) begin
            ms_cnt <= '0;
        end else if (ms_cnt == CNT_LAST) begin
            ms_cnt <= '0;
        end else begin
            ms_cnt <= ms_cnt + 1'b1;
        end
    end

    assign tick = (ms_cnt == CNT_LAST);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-channel reset generator with lock-qualified hold and staggered release
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYS_CYCLE    = 20,
    parameter int MS_WAIT_TIME = 1000000,
    parameter int RST_MS_MAX   = 20,
    parameter int SOFT_MS_MAX  = 2,
    parameter int NUM_CH       = 4,
    parameter int STAGGER_CYC  = 16,
    parameter int LOCK_FILT    = 8
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.master bus
);
    localparam int HOLD_MAX = (RST_MS_MAX > SOFT_MS_MAX) ? RST_MS_MAX : SOFT_MS_MAX;
    localparam int HW       = $clog2(HOLD_MAX + 1);
    localparam int SW       = $clog2(STAGGER_CYC + 1);
    localparam int FW       = $clog2(LOCK_FILT + 1);

    localparam logic [HW-1:0] RST_LIM   = HW'(RST_MS_MAX);
    localparam logic [HW-1:0] SOFT_LIM  = HW'(SOFT_MS_MAX);
    localparam logic [SW-1:0] STG_LAST  = SW'(STAGGER_CYC - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);

    logic [1:0]        lock_sync;
    logic [FW-1:0]     filt_cnt;
    logic              lock_filt_q;
    logic              lock_ok;
    logic              abort;
    logic              ms_en;
    logic              ms_tick;

    state_t            state;
    logic [NUM_CH-1:0] rst_q;
    logic [NUM_CH-1:0] rst_shift;
    logic              done_q;
    logic [HW-1:0]     hold_cnt;
    logic [HW-1:0]     hold_lim;
    logic              hold_soft;
    logic [SW-1:0]     stg;

    // The filter flop alone lags the synchronizer by a cycle; gating with the
    // synced bit makes loss of lock visible on the edge the low value arrives.
    assign lock_ok = lock_filt_q & lock_sync[1];
    assign abort   = bus.soft_rst_req | ~lock_ok;
    assign ms_en   = (state == ST_HOLD) & lock_ok & ~bus.soft_rst_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync   <= 2'b00;
            filt_cnt    <= '0;
            lock_filt_q <= 1'b0;
        end else begin
            lock_sync <= {lock_sync[0], bus.lock_i};
            if (!lock_sync[1]) begin
                filt_cnt    <= '0;
                lock_filt_q <= 1'b0;
            end else if (!lock_filt_q) begin
                if (filt_cnt == FILT_LAST) begin
                    lock_filt_q <= 1'b1;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end
        end
    end

    ms_tick_gen #(
        .SYS_CYCLE    (SYS_CYCLE),
        .MS_WAIT_TIME (MS_WAIT_TIME)
    ) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (ms_en),
        .tick (ms_tick)
    );

    assign hold_lim  = hold_soft ? SOFT_LIM : RST_LIM;
    // Channels drop in index order by shifting zeros in from bit 0.
    assign rst_shift = rst_q << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_HOLD;
            rst_q     <= '1;
            done_q    <= 1'b0;
            hold_cnt  <= '0;
            hold_soft <= 1'b0;
            stg       <= '0;
        end else if (state != ST_HOLD && abort) begin
            state     <= ST_HOLD;
            rst_q     <= '1;
            done_q    <= 1'b0;
            hold_cnt  <= '0;
            hold_soft <= 1'b1;
            stg       <= '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    rst_q  <= '1;
                    done_q <= 1'b0;
                    stg    <= '0;
                    if (bus.soft_rst_req) begin
                        hold_soft <= 1'b1;
                        hold_cnt  <= '0;
                    end else if (!lock_ok) begin
                        hold_cnt <= '0;
                    end else if (ms_tick) begin
                        if (hold_cnt == hold_lim - 1'b1) begin
                            state    <= ST_RELEASE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (stg == STG_LAST) begin
                        stg   <= '0;
                        rst_q <= rst_shift;
                        if (rst_shift == '0) begin
                            state  <= ST_RUN;
                            done_q <= 1'b1;
                        end
                    end else begin
                        stg <= stg + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state  <= ST_HOLD;
                    rst_q  <= '1;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_o   = rst_q;
    assign bus.rst_n_o = ~rst_q;
    assign bus.done_o  = done_q;
    assign bus.state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed timeline and randomized model-checked bench for reset_sequencer
module tb_reset_sequencer;

    localparam int SYS_CYCLE    = 20;
    localparam int MS_WAIT_TIME = 200;
    localparam int RST_MS_MAX   = 3;
    localparam int SOFT_MS_MAX  = 1;
    localparam int NUM_CH       = 4;
    localparam int STAGGER_CYC  = 4;
    localparam int LOCK_FILT    = 4;
    localparam int TICK_CYC     = MS_WAIT_TIME / SYS_CYCLE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    reset_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

    reset_sequencer #(
        .SYS_CYCLE    (SYS_CYCLE),
        .MS_WAIT_TIME (MS_WAIT_TIME),
        .RST_MS_MAX   (RST_MS_MAX),
        .SOFT_MS_MAX  (SOFT_MS_MAX),
        .NUM_CH       (NUM_CH),
        .STAGGER_CYC  (STAGGER_CYC),
        .LOCK_FILT    (LOCK_FILT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: lock is valid once LOCK_FILT+1 consecutive high samples are seen;
    // the hold needs limit*TICK_CYC uninterrupted locked cycles; release progress is elapsed time.
    int m_phase = 0;
    int m_limit = RST_MS_MAX;
    int m_hold  = 0;
    int m_rel   = 0;
    int m_run   = 0;
    bit m_ok    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_limit = RST_MS_MAX; m_hold = 0; m_rel = 0; m_run = 0; m_ok = 1'b0;
        end else begin
            if (m_phase != 0 && (bus.soft_rst_req || !m_ok)) begin
                m_phase = 0; m_limit = SOFT_MS_MAX; m_hold = 0;
            end else if (m_phase == 0) begin
                if (bus.soft_rst_req) begin
                    m_limit = SOFT_MS_MAX; m_hold = 0;
                end else if (!m_ok) begin
                    m_hold = 0;
                end else begin
                    m_hold++;
                    if (m_hold == m_limit * TICK_CYC) begin m_phase = 1; m_rel = 0; end
                end
            end else if (m_phase == 1) begin
                m_rel++;
                if (m_rel == STAGGER_CYC * NUM_CH) m_phase = 2;
            end
            m_ok  = (m_run >= LOCK_FILT + 1);
            m_run = bus.lock_i ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        end
    end

    function automatic logic [3:0] model_rst();
        logic [3:0] v = 4'hF;
        if (m_phase == 2) return 4'h0;
        if (m_phase == 1) return v << (m_rel / STAGGER_CYC);
        return v;
    endfunction

    // Expected outputs k edges into a sequence whose RELEASE is entered on edge r.
    function automatic logic [3:0] exp_tl(input int k, input int r);
        logic [3:0] v = 4'hF;
        if (k < r) return v;
        if ((k - r) / STAGGER_CYC >= NUM_CH) return 4'h0;
        return v << ((k - r) / STAGGER_CYC);
    endfunction

    function automatic logic [1:0] exp_st(input int k, input int r);
        if (k < r) return 2'd0;
        if (k < r + STAGGER_CYC * NUM_CH) return 2'd1;
        return 2'd2;
    endfunction

    task automatic test_reset();
        rst = 1'b1; bus.lock_i = 1'b1; bus.soft_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.rst_o !== 4'hF) begin n_fail++; $display("FAIL reset_rst_o actual=%h required=F", bus.rst_o); end
        n_checks++; if (bus.rst_n_o !== 4'h0) begin n_fail++; $display("FAIL reset_rst_n_o actual=%h required=0", bus.rst_n_o); end
        n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done actual=%b required=0", bus.done_o); end
        n_checks++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state actual=%0d required=0", bus.state_o); end
        rst = 1'b0;
    endtask

    task automatic test_power_on();
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            n_checks++; if (bus.rst_o !== exp_tl(k, 36)) begin n_fail++; $display("FAIL power_on_rst_o k=%0d actual=%h required=%h", k, bus.rst_o, exp_tl(k, 36)); end
            n_checks++; if (bus.rst_n_o !== ~exp_tl(k, 36)) begin n_fail++; $display("FAIL power_on_rst_n_o k=%0d actual=%h required=%h", k, bus.rst_n_o, ~exp_tl(k, 36)); end
            n_checks++; if (bus.done_o !== (k >= 52)) begin n_fail++; $display("FAIL power_on_done k=%0d actual=%b required=%b", k, bus.done_o, k >= 52); end
            n_checks++; if (bus.state_o !== exp_st(k, 36)) begin n_fail++; $display("FAIL power_on_state k=%0d actual=%0d required=%0d", k, bus.state_o, exp_st(k, 36)); end
        end
    endtask

    task automatic test_lock_low();
        rst = 1'b1; bus.lock_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 106; k++) begin
            @(negedge clk);
            n_checks++; if (bus.rst_o !== exp_tl(k, 86)) begin n_fail++; $display("FAIL lock_low_rst_o k=%0d actual=%h required=%h", k, bus.rst_o, exp_tl(k, 86)); end
            n_checks++; if (bus.done_o !== (k >= 102)) begin n_fail++; $display("FAIL lock_low_done k=%0d actual=%b required=%b", k, bus.done_o, k >= 102); end
            n_checks++; if (bus.state_o !== exp_st(k, 86)) begin n_fail++; $display("FAIL lock_low_state k=%0d actual=%0d required=%0d", k, bus.state_o, exp_st(k, 86)); end
            if (k == 50) bus.lock_i = 1'b1;
        end
    endtask

    task automatic test_soft_run();
        bus.soft_rst_req = 1'b1;
        @(negedge clk);
        bus.soft_rst_req = 1'b0;
        n_checks++; if (bus.rst_o !== 4'hF) begin n_fail++; $display("FAIL soft_run_abort_rst_o actual=%h required=F", bus.rst_o); end
        n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL soft_run_abort_done actual=%b required=0", bus.done_o); end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_checks++; if (bus.rst_o !== exp_tl(k, 10)) begin n_fail++; $display("FAIL soft_run_rst_o k=%0d actual=%h required=%h", k, bus.rst_o, exp_tl(k, 10)); end
            n_checks++; if (bus.rst_n_o !== ~bus.rst_o) begin n_fail++; $display("FAIL soft_run_rst_n_o k=%0d actual=%h required=%h", k, bus.rst_n_o, ~bus.rst_o); end
            n_checks++; if (bus.done_o !== (k >= 26)) begin n_fail++; $display("FAIL soft_run_done k=%0d actual=%b required=%b", k, bus.done_o, k >= 26); end
        end
    endtask

    task automatic test_lock_drop();
        int waited = 0;
        int bad = 0;
        bus.soft_rst_req = 1'b1;
        @(negedge clk);
        bus.soft_rst_req = 1'b0;
        while (bus.rst_o !== 4'hC && waited < 60) begin @(negedge clk); waited++; end
        n_checks++; if (bus.rst_o !== 4'hC) begin n_fail++; $display("FAIL lock_drop_wait_C actual=%h required=C", bus.rst_o); end
        repeat (2) @(negedge clk);
        bus.lock_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.rst_o !== 4'h8) begin n_fail++; $display("FAIL lock_drop_pre_abort actual=%h required=8", bus.rst_o); end
        @(negedge clk);
        n_checks++; if (bus.rst_o !== 4'hF) begin n_fail++; $display("FAIL lock_drop_abort_rst_o actual=%h required=F", bus.rst_o); end
        n_checks++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL lock_drop_abort_state actual=%0d required=0", bus.state_o); end
        repeat (20) begin
            @(negedge clk);
            if (bus.rst_o !== 4'hF || bus.state_o !== 2'd0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL lock_drop_held cycles_not_held=%0d required=0", bad); end
        bus.lock_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_checks++; if (bus.rst_o !== exp_tl(k, 16)) begin n_fail++; $display("FAIL lock_drop_resume_rst_o k=%0d actual=%h required=%h", k, bus.rst_o, exp_tl(k, 16)); end
            n_checks++; if (bus.done_o !== (k >= 32)) begin n_fail++; $display("FAIL lock_drop_resume_done k=%0d actual=%b required=%b", k, bus.done_o, k >= 32); end
        end
    endtask

    task automatic test_async_rst();
        int waited = 0;
        bus.soft_rst_req = 1'b1;
        @(negedge clk);
        bus.soft_rst_req = 1'b0;
        while (bus.rst_o !== 4'hE && waited < 60) begin @(negedge clk); waited++; end
        n_checks++; if (bus.rst_o !== 4'hE) begin n_fail++; $display("FAIL async_wait_E actual=%h required=E", bus.rst_o); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.rst_o !== 4'hF) begin n_fail++; $display("FAIL async_rst_o actual=%h required=F", bus.rst_o); end
        n_checks++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL async_state actual=%0d required=0", bus.state_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            n_checks++; if (bus.rst_o !== exp_tl(k, 36)) begin n_fail++; $display("FAIL async_rehold_rst_o k=%0d actual=%h required=%h", k, bus.rst_o, exp_tl(k, 36)); end
            n_checks++; if (bus.done_o !== (k >= 52)) begin n_fail++; $display("FAIL async_rehold_done k=%0d actual=%b required=%b", k, bus.done_o, k >= 52); end
        end
    endtask

    task automatic test_soft_last_edge();
        int waited = 0;
        bus.soft_rst_req = 1'b1;
        @(negedge clk);
        bus.soft_rst_req = 1'b0;
        while (bus.rst_o !== 4'h8 && waited < 60) begin @(negedge clk); waited++; end
        n_checks++; if (bus.rst_o !== 4'h8) begin n_fail++; $display("FAIL last_edge_wait_8 actual=%h required=8", bus.rst_o); end
        repeat (3) @(negedge clk);
        bus.soft_rst_req = 1'b1;
        @(negedge clk);
        bus.soft_rst_req = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++; if (bus.rst_o !== 4'hF) begin n_fail++; $display("FAIL last_edge_rst_o k=%0d actual=%h required=F", k, bus.rst_o); end
            n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL last_edge_done k=%0d actual=%b required=0", k, bus.done_o); end
        end
    endtask

    task automatic test_random();
        int low_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++; if (bus.rst_o !== model_rst()) begin n_fail++; $display("FAIL random_rst_o c=%0d actual=%h required=%h", c, bus.rst_o, model_rst()); end
            n_checks++; if (bus.rst_n_o !== ~model_rst()) begin n_fail++; $display("FAIL random_rst_n_o c=%0d actual=%h required=%h", c, bus.rst_n_o, ~model_rst()); end
            n_checks++; if (bus.done_o !== (m_phase == 2)) begin n_fail++; $display("FAIL random_done c=%0d actual=%b required=%b", c, bus.done_o, m_phase == 2); end
            n_checks++; if (bus.state_o !== 2'(m_phase)) begin n_fail++; $display("FAIL random_state c=%0d actual=%0d required=%0d", c, bus.state_o, m_phase); end
            rst = ($urandom_range(0, 999) == 0);
            bus.soft_rst_req = ($urandom_range(0, 199) == 0);
            if (low_left > 0) low_left--;
            else if ($urandom_range(0, 249) == 0) low_left = $urandom_range(1, 20);
            bus.lock_i = (low_left == 0);
        end
        rst = 1'b0; bus.soft_rst_req = 1'b0; bus.lock_i = 1'b1;
    endtask

    initial begin
        bus.lock_i = 1'b1;
        bus.soft_rst_req = 1'b0;
        test_reset();
        test_power_on();
        test_lock_low();
        test_soft_run();
        test_lock_drop();
        test_async_rst();
        test_soft_last_edge();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
